// File: rtl/alu_ctrl_seq_pkg.sv
// Shared execute-stage ALU control definitions: control codes, funct and alu_op
// encodings, FSM state encoding and the combinational decode function.
package alu_ctrl_seq_pkg;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSll  = 4'b1000;
  localparam logic [3:0] AluSrl  = 4'b1001;
  localparam logic [3:0] AluNor  = 4'b1100;
  localparam logic [3:0] AluMult = 4'b1101;
  localparam logic [3:0] AluDiv  = 4'b1110;

  localparam logic [5:0] FunctAdd  = 6'b100000;
  localparam logic [5:0] FunctSub  = 6'b100010;
  localparam logic [5:0] FunctAnd  = 6'b100100;
  localparam logic [5:0] FunctOr   = 6'b100101;
  localparam logic [5:0] FunctNor  = 6'b100111;
  localparam logic [5:0] FunctSlt  = 6'b101010;
  localparam logic [5:0] FunctSll  = 6'b000000;
  localparam logic [5:0] FunctSrl  = 6'b000010;
  localparam logic [5:0] FunctMult = 6'b011000;
  localparam logic [5:0] FunctDiv  = 6'b011010;

  localparam logic [1:0] OpAdd   = 2'b00;
  localparam logic [1:0] OpSub   = 2'b01;
  localparam logic [1:0] OpRtype = 2'b10;
  localparam logic [1:0] OpSlt   = 2'b11;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  typedef struct packed {
    logic [3:0] code;
    logic       illegal;
    logic       is_md;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] alu_op, input logic [5:0] funct);
    dec_t d;
    d = '{code: AluAdd, illegal: 1'b0, is_md: 1'b0};
    case (alu_op)
      OpAdd:   d.code = AluAdd;
      OpSub:   d.code = AluSub;
      OpSlt:   d.code = AluSlt;
      OpRtype: begin
        case (funct)
          FunctAdd:  d.code = AluAdd;
          FunctSub:  d.code = AluSub;
          FunctAnd:  d.code = AluAnd;
          FunctOr:   d.code = AluOr;
          FunctNor:  d.code = AluNor;
          FunctSlt:  d.code = AluSlt;
          FunctSll:  d.code = AluSll;
          FunctSrl:  d.code = AluSrl;
          FunctMult: begin d.code = AluMult; d.is_md = 1'b1; end
          FunctDiv:  begin d.code = AluDiv;  d.is_md = 1'b1; end
          default:   d.illegal = 1'b1;
        endcase
      end
      default: d.code = AluAdd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Instruction/control bundle between the main decoder side and the ALU control unit.
interface alu_ctrl_seq_if #(
  parameter int unsigned CTRL_W = 4
);
  logic              valid_in;
  logic [5:0]        funct;
  logic [1:0]        alu_op;
  logic              flush;
  logic              valid_out;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              illegal;
  logic              md_start;
  logic              md_busy;
  logic              md_done;
  logic              stall;

  modport master (
    output valid_in, funct, alu_op, flush,
    input  valid_out, alu_ctrl, illegal, md_start, md_busy, md_done, stall
  );

  modport slave (
    input  valid_in, funct, alu_op, flush,
    output valid_out, alu_ctrl, illegal, md_start, md_busy, md_done, stall
  );
endinterface

// File: rtl/alu_ctrl_seq_md_busy_counter.sv
// Load/decrement busy counter for the mult/div unit; tc flags a zero count.
module alu_ctrl_seq_md_busy_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);
endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decode with MULT/DIV busy sequencing and pipeline stall.
module alu_ctrl_seq #(
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu_ctrl_seq_if.slave bus
);
  import alu_ctrl_seq_pkg::*;

  dec_t              dec;
  logic              accept, md_load, busy, tc, stall;
  logic [0:0]        state_q, state_d;
  logic              valid_q, illegal_q;
  logic [CTRL_W-1:0] ctrl_q;

  assign dec     = decode(bus.alu_op, bus.funct);
  assign busy    = (state_q == StBusy);
  assign stall   = busy & ~tc;
  assign accept  = bus.valid_in & ~stall & ~bus.flush;
  assign md_load = accept & dec.is_md;

  // From count 0 a fresh MULT/DIV reloads and keeps BUSY, so no IDLE bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (md_load) state_d = StBusy;
      StBusy:  if (tc && !md_load) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.flush) begin
        valid_q   <= 1'b0;
        illegal_q <= 1'b0;
      end else if (accept) begin
        valid_q   <= 1'b1;
        ctrl_q    <= CTRL_W'(dec.code);
        illegal_q <= dec.illegal;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  alu_ctrl_seq_md_busy_counter #(
    .CNT_W(CNT_W)
  ) u_md_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (md_load),
    .load_val (CNT_W'(MD_LATENCY - 1)),
    .dec      (stall),
    .tc       (tc)
  );

  assign bus.valid_out = valid_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.illegal   = illegal_q;
  assign bus.md_start  = valid_q & ((ctrl_q == CTRL_W'(AluMult)) | (ctrl_q == CTRL_W'(AluDiv)));
  assign bus.md_busy   = busy;
  assign bus.md_done   = busy & tc;
  assign bus.stall     = stall;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed scoreboard bench for alu_ctrl_seq with MD_LATENCY = 4.
module tb_alu_ctrl_seq;
  typedef struct packed {
    logic       vo;
    logic [3:0] ctrl;
    logic       ill;
    logic       st;
    logic       bu;
    logic       dn;
    logic       sl;
  } exp_t;

  localparam logic [1:0] OA = 2'b00, OS = 2'b01, OR = 2'b10, OT = 2'b11;
  localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100;
  localparam logic [5:0] FOR = 6'b100101, FNOR = 6'b100111, FSLT = 6'b101010;
  localparam logic [5:0] FSLL = 6'b000000, FSRL = 6'b000010, FMUL = 6'b011000;
  localparam logic [5:0] FDIV = 6'b011010, FBAD = 6'b111111;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.CTRL_W(4)) bus ();

  alu_ctrl_seq #(
    .CTRL_W     (4),
    .MD_LATENCY (4),
    .CNT_W      (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic exp_t mk(input logic vo, input logic [3:0] ctrl, input logic ill,
                              input logic st, input logic bu, input logic dn, input logic sl);
    return '{vo: vo, ctrl: ctrl, ill: ill, st: st, bu: bu, dn: dn, sl: sl};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL step %0d %s: observed=%0h expected=%0h", step_no, tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected in the next cycle.
  task automatic step(input logic rst, input logic v, input logic [1:0] op,
                      input logic [5:0] fn, input logic fl, input exp_t e);
    exp_t got;
    rst_n        = rst;
    bus.valid_in = v;
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.flush    = fl;
    q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    got = q.pop_front();
    check("valid_out", {3'b0, bus.valid_out}, {3'b0, got.vo});
    check("alu_ctrl",  bus.alu_ctrl,          got.ctrl);
    check("illegal",   {3'b0, bus.illegal},   {3'b0, got.ill});
    check("md_start",  {3'b0, bus.md_start},  {3'b0, got.st});
    check("md_busy",   {3'b0, bus.md_busy},   {3'b0, got.bu});
    check("md_done",   {3'b0, bus.md_done},   {3'b0, got.dn});
    check("stall",     {3'b0, bus.stall},     {3'b0, got.sl});
  endtask

  task automatic idle(input exp_t e);
    step(1'b1, 1'b0, OA, FSLL, 1'b0, e);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    bus.alu_op = OA;
    bus.funct = FSLL;
    bus.flush = 1'b0;

    // Reset, then decode sweep
    step(1'b0, 1'b0, OA, FSLL, 1'b0, mk(0, 4'h0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1, OR, FMUL, 1'b0, mk(0, 4'h0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, OR, FADD, 1'b0, mk(1, 4'h2, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, OA, FBAD, 1'b0, mk(1, 4'h2, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, OS, FBAD, 1'b0, mk(1, 4'h6, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, OT, FBAD, 1'b0, mk(1, 4'h7, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, OR, FBAD, 1'b0, mk(1, 4'h2, 1, 0, 0, 0, 0));
    step(1'b1, 1'b1, OR, FAND, 1'b0, mk(1, 4'h0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, OR, FOR,  1'b0, mk(1, 4'h1, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, OR, FNOR, 1'b0, mk(1, 4'hC, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, OR, FSLT, 1'b0, mk(1, 4'h7, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, OR, FSLL, 1'b0, mk(1, 4'h8, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, OR, FSRL, 1'b0, mk(1, 4'h9, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, OR, FSUB, 1'b0, mk(1, 4'h6, 0, 0, 0, 0, 0));
    idle(mk(0, 4'h6, 0, 0, 0, 0, 0));

    // MULT, ADD held through the stall, accepted at the md_done edge
    step(1'b1, 1'b1, OR, FMUL, 1'b0, mk(1, 4'hD, 0, 1, 1, 0, 1));
    step(1'b1, 1'b1, OA, FBAD, 1'b0, mk(0, 4'hD, 0, 0, 1, 0, 1));
    step(1'b1, 1'b1, OA, FBAD, 1'b0, mk(0, 4'hD, 0, 0, 1, 0, 1));
    step(1'b1, 1'b1, OA, FBAD, 1'b0, mk(0, 4'hD, 0, 0, 1, 1, 0));
    step(1'b1, 1'b1, OA, FBAD, 1'b0, mk(1, 4'h2, 0, 0, 0, 0, 0));

    // Back-to-back MULT then DIV
    step(1'b1, 1'b1, OR, FMUL, 1'b0, mk(1, 4'hD, 0, 1, 1, 0, 1));
    step(1'b1, 1'b1, OR, FDIV, 1'b0, mk(0, 4'hD, 0, 0, 1, 0, 1));
    step(1'b1, 1'b1, OR, FDIV, 1'b0, mk(0, 4'hD, 0, 0, 1, 0, 1));
    step(1'b1, 1'b1, OR, FDIV, 1'b0, mk(0, 4'hD, 0, 0, 1, 1, 0));
    step(1'b1, 1'b1, OR, FDIV, 1'b0, mk(1, 4'hE, 0, 1, 1, 0, 1));
    idle(mk(0, 4'hE, 0, 0, 1, 0, 1));
    idle(mk(0, 4'hE, 0, 0, 1, 0, 1));
    idle(mk(0, 4'hE, 0, 0, 1, 1, 0));
    idle(mk(0, 4'hE, 0, 0, 0, 0, 0));

    // Flush with MULT prevents launch
    step(1'b1, 1'b1, OR, FMUL, 1'b1, mk(0, 4'hE, 0, 0, 0, 0, 0));
    idle(mk(0, 4'hE, 0, 0, 0, 0, 0));

    // Flush during BUSY leaves the sequence running
    step(1'b1, 1'b1, OR, FMUL, 1'b0, mk(1, 4'hD, 0, 1, 1, 0, 1));
    step(1'b1, 1'b0, OA, FSLL, 1'b1, mk(0, 4'hD, 0, 0, 1, 0, 1));
    step(1'b1, 1'b0, OA, FSLL, 1'b1, mk(0, 4'hD, 0, 0, 1, 0, 1));
    step(1'b1, 1'b0, OA, FSLL, 1'b1, mk(0, 4'hD, 0, 0, 1, 1, 0));
    idle(mk(0, 4'hD, 0, 0, 0, 0, 0));

    // Flush clears held valid/illegal, alu_ctrl holds
    step(1'b1, 1'b1, OR, FBAD, 1'b0, mk(1, 4'h2, 1, 0, 0, 0, 0));
    step(1'b1, 1'b1, OS, FBAD, 1'b1, mk(0, 4'h2, 0, 0, 0, 0, 0));

    // Reset in cycle 2 of BUSY aborts the sequence
    step(1'b1, 1'b1, OR, FDIV, 1'b0, mk(1, 4'hE, 0, 1, 1, 0, 1));
    idle(mk(0, 4'hE, 0, 0, 1, 0, 1));
    step(1'b0, 1'b0, OA, FSLL, 1'b0, mk(0, 4'h0, 0, 0, 0, 0, 0));
    idle(mk(0, 4'h0, 0, 0, 0, 0, 0));
    idle(mk(0, 4'h0, 0, 0, 0, 0, 0));
    idle(mk(0, 4'h0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
